// File: rtl/dbg_slave_pkg.sv
// Shared constants and types for the CPU debug slave (TCK and system-clock halves).
package dbg_slave_pkg;

  localparam int unsigned SrWidthDefault   = 38;
  localparam int unsigned IrWidthDefault   = 2;
  localparam int unsigned ActBitDefault    = SrWidthDefault - 1;
  localparam int unsigned ClrOvrBitDefault = SrWidthDefault - 2;

  typedef enum logic [0:0] {
    StIdle,
    StDispatch
  } disp_state_e;

  function automatic int unsigned act_bit(input int unsigned sr_width);
    return sr_width - 1;
  endfunction

  function automatic int unsigned clr_ovr_bit(input int unsigned sr_width);
    return sr_width - 2;
  endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser with an arm flag and rise detector for a TCK-domain level.
module dbg_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   arm_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // fill_q marks when the last stage holds a real post-reset sample, so the reset
  // value of the chain cannot arm the detector for a line held high through reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= synced;
      if (fill_q[SYNC_STAGES-1] && !synced) begin
        arm_q <= 1'b1;
      end
    end
  end

  assign rise = synced & ~prev_q & arm_q;

endmodule

// File: rtl/dbg_slave_sysclk_dispatch.sv
// System-clock half of the debug slave: latches JTAG commands and dispatches
// per-channel action/no-action strobes with a pending/ack handshake.
module dbg_slave_sysclk_dispatch
  import dbg_slave_pkg::*;
#(
  parameter int unsigned SR_WIDTH    = SrWidthDefault,
  parameter int unsigned IR_WIDTH    = IrWidthDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IR_WIDTH-1:0]       ir_in,
  input  logic [SR_WIDTH-1:0]       sr,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic [2**IR_WIDTH-1:0]    ch_ack,
  output logic [SR_WIDTH-1:0]       jdo,
  output logic [IR_WIDTH-1:0]       ir_q,
  output logic [2**IR_WIDTH-1:0]    take_action,
  output logic [2**IR_WIDTH-1:0]    take_no_action,
  output logic [2**IR_WIDTH-1:0]    ch_pending,
  output logic [2**IR_WIDTH-1:0]    ch_overrun,
  output logic [2*(2**IR_WIDTH)-1:0] status
);

  localparam int unsigned NumCh     = 2**IR_WIDTH;
  localparam int unsigned ActBit    = act_bit(SR_WIDTH);
  localparam int unsigned ClrOvrBit = clr_ovr_bit(SR_WIDTH);

  logic               udr_rise;
  logic               uir_rise;
  disp_state_e        state_q;
  logic [IR_WIDTH-1:0] ch_q;
  logic [NumCh-1:0]   pend_eff;

  dbg_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_udr (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (vs_udr),
    .rise   (udr_rise)
  );

  dbg_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_uir (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (vs_uir),
    .rise   (uir_rise)
  );

  // Acks are applied before the dispatch decision in the same cycle.
  assign pend_eff = ch_pending & ~ch_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      jdo            <= '0;
      ir_q           <= '0;
      ch_q           <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ch_pending     <= '0;
      ch_overrun     <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      ch_pending     <= pend_eff;
      if (uir_rise) begin
        ir_q <= ir_in;
      end
      unique case (state_q)
        StIdle: begin
          if (udr_rise) begin
            jdo     <= sr;
            ch_q    <= uir_rise ? ir_in : ir_q;
            state_q <= StDispatch;
          end
        end
        StDispatch: begin
          state_q <= StIdle;
          if (jdo[ActBit]) begin
            if (pend_eff[ch_q]) begin
              ch_overrun[ch_q] <= 1'b1;
            end else begin
              take_action[ch_q] <= 1'b1;
              ch_pending[ch_q]  <= 1'b1;
            end
          end else begin
            take_no_action[ch_q] <= 1'b1;
            if (jdo[ClrOvrBit]) begin
              ch_overrun[ch_q] <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign status = {ch_overrun, ch_pending};

endmodule

// File: tb/tb_dbg_slave_sysclk_dispatch.sv
// Directed bench: default instance (SYNC_STAGES=2, 4 channels) and a
// SYNC_STAGES=3 / 8-channel instance.
module tb_dbg_slave_sysclk_dispatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: defaults
  logic        reset_n_a;
  logic [1:0]  ir_in_a;
  logic [37:0] sr_a;
  logic        vs_udr_a, vs_uir_a;
  logic [3:0]  ch_ack_a;
  logic [37:0] jdo_a;
  logic [1:0]  ir_q_a;
  logic [3:0]  take_action_a, take_no_action_a, ch_pending_a, ch_overrun_a;
  logic [7:0]  status_a;

  // Instance B: SYNC_STAGES=3, IR_WIDTH=3
  logic        reset_n_b;
  logic [2:0]  ir_in_b;
  logic [37:0] sr_b;
  logic        vs_udr_b, vs_uir_b;
  logic [7:0]  ch_ack_b;
  logic [37:0] jdo_b;
  logic [2:0]  ir_q_b;
  logic [7:0]  take_action_b, take_no_action_b, ch_pending_b, ch_overrun_b;
  logic [15:0] status_b;

  logic [7:0] acc_act, acc_noact;
  int         n_strobe;

  dbg_slave_sysclk_dispatch u_dut_a (
    .clk           (clk),
    .reset_n       (reset_n_a),
    .ir_in         (ir_in_a),
    .sr            (sr_a),
    .vs_udr        (vs_udr_a),
    .vs_uir        (vs_uir_a),
    .ch_ack        (ch_ack_a),
    .jdo           (jdo_a),
    .ir_q          (ir_q_a),
    .take_action   (take_action_a),
    .take_no_action(take_no_action_a),
    .ch_pending    (ch_pending_a),
    .ch_overrun    (ch_overrun_a),
    .status        (status_a)
  );

  dbg_slave_sysclk_dispatch #(
    .SR_WIDTH   (38),
    .IR_WIDTH   (3),
    .SYNC_STAGES(3)
  ) u_dut_b (
    .clk           (clk),
    .reset_n       (reset_n_b),
    .ir_in         (ir_in_b),
    .sr            (sr_b),
    .vs_udr        (vs_udr_b),
    .vs_uir        (vs_uir_b),
    .ch_ack        (ch_ack_b),
    .jdo           (jdo_b),
    .ir_q          (ir_q_b),
    .take_action   (take_action_b),
    .take_no_action(take_no_action_b),
    .ch_pending    (ch_pending_b),
    .ch_overrun    (ch_overrun_b),
    .status        (status_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int n);
    acc_act   = '0;
    acc_noact = '0;
    n_strobe  = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      acc_act   |= 8'(take_action_a);
      acc_noact |= 8'(take_no_action_a);
      if (|{take_action_a, take_no_action_a}) n_strobe++;
    end
  endtask

  task automatic run_b(input int n);
    acc_act   = '0;
    acc_noact = '0;
    n_strobe  = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      acc_act   |= take_action_b;
      acc_noact |= take_no_action_b;
      if (|{take_action_b, take_no_action_b}) n_strobe++;
    end
  endtask

  // One udr command on instance A, then the line returns low long enough to re-arm.
  task automatic udr_a(input logic [37:0] v);
    sr_a     = v;
    vs_udr_a = 1'b1;
    run_a(6);
    vs_udr_a = 1'b0;
    step(4);
  endtask

  initial begin
    reset_n_a = 1'b0; ir_in_a = '0; sr_a = '0; vs_udr_a = 1'b1; vs_uir_a = 1'b0; ch_ack_a = '0;
    reset_n_b = 1'b0; ir_in_b = '0; sr_b = '0; vs_udr_b = 1'b0; vs_uir_b = 1'b0; ch_ack_b = '0;
    step(3);
    check("a_reset_jdo", 64'(jdo_a), 64'h0);
    check("a_reset_status", 64'(status_a), 64'h0);
    check("b_reset_status", 64'(status_b), 64'h0);

    // udr held high through reset release must not dispatch
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    run_a(20);
    check("a_hold_high_strobes", 64'(n_strobe), 64'd0);
    check("a_hold_high_jdo", 64'(jdo_a), 64'h0);
    check("a_hold_high_status", 64'(status_a), 64'h0);
    vs_udr_a = 1'b0;
    step(5);

    // Latch IR = 2
    ir_in_a  = 2'd2;
    vs_uir_a = 1'b1;
    step(4);
    check("a_ir_q", 64'(ir_q_a), 64'd2);
    vs_uir_a = 1'b0;
    step(3);

    // First action to ch2 with exact latency
    sr_a     = 38'h20_0000_0055;
    vs_udr_a = 1'b1;
    step(2);
    check("a_jdo_not_yet", 64'(jdo_a), 64'h0);
    step(1);
    check("a_jdo_latency", 64'(jdo_a), 64'h20_0000_0055);
    check("a_act_early", 64'(take_action_a), 64'h0);
    step(1);
    check("a_act_strobe", 64'(take_action_a), 64'h4);
    check("a_noact_quiet", 64'(take_no_action_a), 64'h0);
    check("a_pending_set", 64'(ch_pending_a), 64'h4);
    step(1);
    check("a_act_one_cycle", 64'(take_action_a), 64'h0);
    vs_udr_a = 1'b0;
    step(4);

    // Second action without ack: dropped, overrun flagged, jdo still updates
    udr_a(38'h20_0000_00AA);
    check("a_ovr_no_strobe", 64'(n_strobe), 64'd0);
    check("a_ovr_jdo", 64'(jdo_a), 64'h20_0000_00AA);
    check("a_ovr_status", 64'(status_a), 64'h44);

    // No-action with clear-overrun bit
    udr_a(38'h10_0000_0000);
    check("a_clr_noact", 64'(acc_noact), 64'h4);
    check("a_clr_count", 64'(n_strobe), 64'd1);
    check("a_clr_act", 64'(acc_act), 64'h0);
    check("a_clr_status", 64'(status_a), 64'h04);

    // Ack in the dispatch cycle: accepted, pending stays, no overrun
    sr_a     = 38'h20_0000_0077;
    vs_udr_a = 1'b1;
    step(3);
    ch_ack_a = 4'h4;
    step(1);
    ch_ack_a = 4'h0;
    check("a_ackdisp_act", 64'(take_action_a), 64'h4);
    check("a_ackdisp_status", 64'(status_a), 64'h04);
    step(1);
    check("a_ackdisp_one_cycle", 64'(take_action_a), 64'h0);
    vs_udr_a = 1'b0;
    step(4);

    // Plain ack clears pending; a second ack is harmless
    ch_ack_a = 4'h4;
    step(1);
    check("a_ack_clear", 64'(ch_pending_a), 64'h0);
    step(1);
    ch_ack_a = 4'h0;
    check("a_ack_idle", 64'(status_a), 64'h0);

    // Simultaneous uir and udr: dispatch uses the new IR
    ir_in_a  = 2'd1;
    vs_uir_a = 1'b1;
    udr_a(38'h00_0000_0000);
    vs_uir_a = 1'b0;
    check("a_simul_noact", 64'(acc_noact), 64'h2);
    check("a_simul_count", 64'(n_strobe), 64'd1);
    check("a_simul_ir", 64'(ir_q_a), 64'd1);
    check("a_simul_pending", 64'(ch_pending_a), 64'h0);

    // Instance B: IR = 7, action with SYNC_STAGES = 3
    ir_in_b  = 3'd7;
    vs_uir_b = 1'b1;
    step(6);
    vs_uir_b = 1'b0;
    check("b_ir_q", 64'(ir_q_b), 64'd7);
    step(5);
    sr_b     = 38'h20_0000_0001;
    vs_udr_b = 1'b1;
    step(4);
    check("b_jdo_latency", 64'(jdo_b), 64'h20_0000_0001);
    check("b_act_early", 64'(take_action_b), 64'h0);
    step(1);
    check("b_act_cycle5", 64'(take_action_b), 64'h80);
    check("b_noact_quiet", 64'(take_no_action_b), 64'h0);
    step(1);
    check("b_act_one_cycle", 64'(take_action_b), 64'h0);
    check("b_status", 64'(status_b), 64'h0080);
    vs_udr_b = 1'b0;
    step(6);
    ch_ack_b = 8'h80;
    step(1);
    ch_ack_b = 8'h00;
    check("b_ack", 64'(ch_pending_b), 64'h0);

    // Reset in the dispatch cycle cancels the strobe
    sr_b     = 38'h20_0000_0002;
    vs_udr_b = 1'b1;
    step(4);
    check("b_in_dispatch_jdo", 64'(jdo_b), 64'h20_0000_0002);
    reset_n_b = 1'b0;
    run_b(2);
    check("b_rst_no_strobe", 64'(n_strobe), 64'd0);
    check("b_rst_jdo", 64'(jdo_b), 64'h0);
    check("b_rst_status", 64'(status_b), 64'h0);
    reset_n_b = 1'b1;
    run_b(10);
    check("b_post_rst_quiet", 64'(n_strobe), 64'd0);
    vs_udr_b = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
